// File: rtl/riscv_reg_file_if.sv
// Purpose: decode/writeback-facing bus of the integer register file (two read ports, one write port).
// Latency: reads are combinational; a write lands on the rising clock edge.
// Backpressure: none; the register file accepts a read and a write every cycle.
interface riscv_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadAddr_1;
  logic [ADDR_W-1:0] ReadAddr_2;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic              RegRead_1;
  logic              RegRead_2;
  logic              RegWrite;
  logic [DATA_W-1:0] ReadData_1;
  logic [DATA_W-1:0] ReadData_2;

  // Pipeline side: drives indices, enables and write data, consumes read data.
  modport master (
    output ReadAddr_1, ReadAddr_2, WriteAddr, WriteData,
    output RegRead_1, RegRead_2, RegWrite,
    input  ReadData_1, ReadData_2
  );

  // Register file side.
  modport slave (
    input  ReadAddr_1, ReadAddr_2, WriteAddr, WriteData,
    input  RegRead_1, RegRead_2, RegWrite,
    output ReadData_1, ReadData_2
  );
endinterface

// File: rtl/riscv_reg_file.sv
// Purpose: 32 x 32-bit RISC-V integer register file, x0 hardwired to zero, every register on a debug port.
// Latency: zero-cycle combinational reads with same-cycle write bypass; writes commit on the rising edge.
// Backpressure: none; one write and two reads can be accepted every cycle.
module riscv_reg_file #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32   // must equal 2**ADDR_W so every index maps to a register
) (
  input  logic              sys_clk,
  input  logic              rstn,
  riscv_reg_file_if.slave   rf,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  output logic [DATA_W-1:0] x5,
  output logic [DATA_W-1:0] x6,
  output logic [DATA_W-1:0] x7,
  output logic [DATA_W-1:0] x8,
  output logic [DATA_W-1:0] x9,
  output logic [DATA_W-1:0] x10,
  output logic [DATA_W-1:0] x11,
  output logic [DATA_W-1:0] x12,
  output logic [DATA_W-1:0] x13,
  output logic [DATA_W-1:0] x14,
  output logic [DATA_W-1:0] x15,
  output logic [DATA_W-1:0] x16,
  output logic [DATA_W-1:0] x17,
  output logic [DATA_W-1:0] x18,
  output logic [DATA_W-1:0] x19,
  output logic [DATA_W-1:0] x20,
  output logic [DATA_W-1:0] x21,
  output logic [DATA_W-1:0] x22,
  output logic [DATA_W-1:0] x23,
  output logic [DATA_W-1:0] x24,
  output logic [DATA_W-1:0] x25,
  output logic [DATA_W-1:0] x26,
  output logic [DATA_W-1:0] x27,
  output logic [DATA_W-1:0] x28,
  output logic [DATA_W-1:0] x29,
  output logic [DATA_W-1:0] x30,
  output logic [DATA_W-1:0] x31
);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic              wr_vld;
  logic [DATA_W-1:0] rd1_dat;
  logic [DATA_W-1:0] rd2_dat;

  // A write to x0 is dropped here so storage for index 0 never leaves zero.
  assign wr_vld = rf.RegWrite && (rf.WriteAddr != '0);

  // Storage: async clear wins over any write in flight; otherwise commit the qualified write.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_vld) begin
      regs_q[rf.WriteAddr] <= rf.WriteData;
    end
  end

  // Port 1 read: gated by enable and reset, forwards same-cycle write data so decode sees writeback.
  always_comb begin
    rd1_dat = '0;
    if (rstn && rf.RegRead_1 && (rf.ReadAddr_1 != '0)) begin
      if (wr_vld && (rf.WriteAddr == rf.ReadAddr_1)) begin
        rd1_dat = rf.WriteData;
      end else begin
        rd1_dat = regs_q[rf.ReadAddr_1];
      end
    end
  end

  // Port 2 read: identical to port 1 and fully independent of it.
  always_comb begin
    rd2_dat = '0;
    if (rstn && rf.RegRead_2 && (rf.ReadAddr_2 != '0)) begin
      if (wr_vld && (rf.WriteAddr == rf.ReadAddr_2)) begin
        rd2_dat = rf.WriteData;
      end else begin
        rd2_dat = regs_q[rf.ReadAddr_2];
      end
    end
  end

  assign rf.ReadData_1 = rd1_dat;
  assign rf.ReadData_2 = rd2_dat;

  // Debug taps; x0 is tied off rather than read from storage.
  assign x0  = '0;
  assign x1  = regs_q[1];
  assign x2  = regs_q[2];
  assign x3  = regs_q[3];
  assign x4  = regs_q[4];
  assign x5  = regs_q[5];
  assign x6  = regs_q[6];
  assign x7  = regs_q[7];
  assign x8  = regs_q[8];
  assign x9  = regs_q[9];
  assign x10 = regs_q[10];
  assign x11 = regs_q[11];
  assign x12 = regs_q[12];
  assign x13 = regs_q[13];
  assign x14 = regs_q[14];
  assign x15 = regs_q[15];
  assign x16 = regs_q[16];
  assign x17 = regs_q[17];
  assign x18 = regs_q[18];
  assign x19 = regs_q[19];
  assign x20 = regs_q[20];
  assign x21 = regs_q[21];
  assign x22 = regs_q[22];
  assign x23 = regs_q[23];
  assign x24 = regs_q[24];
  assign x25 = regs_q[25];
  assign x26 = regs_q[26];
  assign x27 = regs_q[27];
  assign x28 = regs_q[28];
  assign x29 = regs_q[29];
  assign x30 = regs_q[30];
  assign x31 = regs_q[31];

endmodule

// File: tb/tb_riscv_reg_file.sv
// Purpose: directed self-checking bench for riscv_reg_file with a reference model and expectation queue.
// Latency: reads sampled 1 ns after inputs change; writes checked 1 ns after the rising edge.
// Backpressure: not applicable.
module tb_riscv_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RN = 32;

  logic          sys_clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] xdbg [RN];

  riscv_reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) rf ();

  riscv_reg_file #(.DATA_W(DW), .ADDR_W(AW), .REG_NUM(RN)) dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .rf      (rf),
    .x0  (xdbg[0]),  .x1  (xdbg[1]),  .x2  (xdbg[2]),  .x3  (xdbg[3]),
    .x4  (xdbg[4]),  .x5  (xdbg[5]),  .x6  (xdbg[6]),  .x7  (xdbg[7]),
    .x8  (xdbg[8]),  .x9  (xdbg[9]),  .x10 (xdbg[10]), .x11 (xdbg[11]),
    .x12 (xdbg[12]), .x13 (xdbg[13]), .x14 (xdbg[14]), .x15 (xdbg[15]),
    .x16 (xdbg[16]), .x17 (xdbg[17]), .x18 (xdbg[18]), .x19 (xdbg[19]),
    .x20 (xdbg[20]), .x21 (xdbg[21]), .x22 (xdbg[22]), .x23 (xdbg[23]),
    .x24 (xdbg[24]), .x25 (xdbg[25]), .x26 (xdbg[26]), .x27 (xdbg[27]),
    .x28 (xdbg[28]), .x29 (xdbg[29]), .x30 (xdbg[30]), .x31 (xdbg[31])
  );

  always #5 sys_clk = ~sys_clk;

  logic [DW-1:0] model [RN];
  logic [DW-1:0] exp_q [$];
  int passed = 0;
  int total  = 0;

  // Reference read value computed only from bench-driven inputs and the model.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input logic en);
    if (!rstn || !en || a == '0) return '0;
    if (rf.RegWrite && rf.WriteAddr != '0 && rf.WriteAddr == a) return rf.WriteData;
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
  endtask

  task automatic set_reads(input string tag, input logic [AW-1:0] a1, input logic e1,
                           input logic [AW-1:0] a2, input logic e2);
    rf.ReadAddr_1 = a1; rf.RegRead_1 = e1;
    rf.ReadAddr_2 = a2; rf.RegRead_2 = e2;
    exp_q.push_back(exp_rd(a1, e1));
    exp_q.push_back(exp_rd(a2, e2));
    #1;
    check({tag, "_rd1"}, rf.ReadData_1);
    check({tag, "_rd2"}, rf.ReadData_2);
  endtask

  task automatic check_x_all(input string tag);
    for (int i = 0; i < RN; i++) exp_q.push_back(model[i]);
    for (int i = 0; i < RN; i++) check($sformatf("%s_x%0d", tag, i), xdbg[i]);
  endtask

  task automatic check_x(input string tag, input int idx);
    exp_q.push_back(model[idx]);
    check($sformatf("%s_x%0d", tag, idx), xdbg[idx]);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge sys_clk);
    rf.RegWrite = 1'b1; rf.WriteAddr = a; rf.WriteData = d;
    @(posedge sys_clk);
    if (rstn && a != '0) model[a] = d;
    #1;
    rf.RegWrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < RN; i++) model[i] = '0;
    // Reset held with live reads and a pending write that must be ignored.
    rstn = 1'b0;
    rf.RegWrite = 1'b1; rf.WriteAddr = 5'd3; rf.WriteData = $urandom;
    rf.ReadAddr_1 = '0; rf.ReadAddr_2 = '0; rf.RegRead_1 = 1'b1; rf.RegRead_2 = 1'b1;
    #19;
    set_reads("reset", AW'($urandom_range(31)), 1'b1, AW'($urandom_range(31)), 1'b1);
    check_x_all("reset");
    @(negedge sys_clk);
    rf.RegWrite = 1'b0;
    rstn = 1'b1;

    // Fill x1..x31 and check each lands after its edge.
    for (int i = 1; i < RN; i++) begin
      do_write(AW'(i), 32'hA5A5_0000 + DW'(i));
      check_x("fill", i);
    end
    check_x_all("fill_all");

    // Opposing read sweeps.
    for (int i = 0; i < RN; i++) begin
      @(negedge sys_clk);
      set_reads($sformatf("sweep%0d", i), AW'(i), 1'b1, AW'(31 - i), 1'b1);
    end

    // x0 protection, including a same-cycle bypass attempt on address 0.
    @(negedge sys_clk);
    rf.RegWrite = 1'b1; rf.WriteAddr = '0; rf.WriteData = 32'hFFFF_FFFF;
    set_reads("x0_byp", 5'd0, 1'b1, 5'd0, 1'b1);
    @(posedge sys_clk);
    #1;
    rf.RegWrite = 1'b0;
    check_x("x0_prot", 0);
    set_reads("x0_rd", 5'd0, 1'b1, 5'd1, 1'b1);

    // Enable gating on a shared address.
    do_write(5'd5, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      set_reads($sformatf("gate%0d", k), 5'd5, ~k[0], 5'd5, ~k[0]);
    end
    @(negedge sys_clk);
    set_reads("gate_split", 5'd5, 1'b1, 5'd5, 1'b0);

    // Write-read bypass on both ports, old value still on the debug tap before the edge.
    do_write(5'd7, 32'h1111_1111);
    @(negedge sys_clk);
    rf.RegWrite = 1'b1; rf.WriteAddr = 5'd7; rf.WriteData = 32'h2222_2222;
    set_reads("bypass", 5'd7, 1'b1, 5'd7, 1'b1);
    check_x("bypass_pre", 7);
    @(posedge sys_clk);
    model[7] = 32'h2222_2222;
    #1;
    rf.RegWrite = 1'b0;
    check_x("bypass_post", 7);
    set_reads("bypass_other", 5'd7, 1'b1, 5'd8, 1'b1);

    // Async reset between edges, then a write racing the reset.
    @(posedge sys_clk);
    #2;
    rstn = 1'b0;
    for (int i = 0; i < RN; i++) model[i] = '0;
    set_reads("arst", 5'd7, 1'b1, 5'd31, 1'b1);
    check_x_all("arst");
    rf.RegWrite = 1'b1; rf.WriteAddr = 5'd9; rf.WriteData = 32'hDEAD_BEEF;
    set_reads("arst_wr", 5'd9, 1'b1, 5'd9, 1'b1);
    @(posedge sys_clk);
    #1;
    check_x("arst_wr", 9);
    rf.RegWrite = 1'b0;
    @(negedge sys_clk);
    #2;
    rstn = 1'b1;
    check_x_all("post_rel");
    set_reads("post_rel", 5'd7, 1'b1, 5'd9, 1'b1);
    do_write(5'd9, 32'hCAFE_F00D);
    check_x("first_wr", 9);
    set_reads("first_wr", 5'd9, 1'b1, 5'd5, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/riscv_reg_file.md
Name: riscv_reg_file

Overview:
- 32 x 32-bit RISC-V integer register file (x0..x31) for the uniprocessor datapath; sits between decode (reads) and writeback (writes).
- Two independent read ports, each with a read enable, and one synchronous write port.
- Every architectural register is also exported as a dedicated debug output for waveform and bench inspection.

Parameters:
- DATA_W, 32, register width in bits (`RegBus`).
- ADDR_W, 5, register address width (`RegAddrBus`).
- REG_NUM, 32, number of registers (`RegNum`); must equal 2**ADDR_W.

Ports:
- sys_clk  input  1  system clock; all writes occur on its rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- ReadAddr_1  input  ADDR_W  read port 1 register index.
- ReadAddr_2  input  ADDR_W  read port 2 register index.
- WriteAddr  input  ADDR_W  write port register index.
- WriteData  input  DATA_W  write data.
- RegRead_1  input  1  read enable, port 1.
- RegRead_2  input  1  read enable, port 2.
- RegWrite  input  1  write enable.
- ReadData_1  output  DATA_W  read data, port 1.
- ReadData_2  output  DATA_W  read data, port 2.
- x0..x31  output  DATA_W each  current stored value of each register (x0 always 0).

Behaviour:
- Clock and reset: single clock sys_clk; reset rstn is asynchronous and active-low.
- Reset: rstn=0 immediately clears all 32 registers to 0, independent of the clock.
  - While rstn=0, ReadData_1, ReadData_2 and x0..x31 are all 0.
  - Writes are ignored while rstn=0.
- Write: on a sys_clk rising edge with rstn=1 and RegWrite=1, reg[WriteAddr] <= WriteData.
  - The new value is visible on x<n> after that edge.
- x0 is hardwired to zero.
  - Writes with WriteAddr=0 are discarded.
  - Reads of address 0 return 0.
  - Debug output x0 is constant 0.
- Read: combinational, zero latency.
  - ReadData_k = reg[ReadAddr_k] when RegRead_k=1 and rstn=1; otherwise ReadData_k = 0.
  - Ports 1 and 2 are fully independent; both may address the same register.
- Write-read bypass: if RegWrite=1, WriteAddr!=0, RegRead_k=1 and ReadAddr_k==WriteAddr in the same cycle, ReadData_k returns WriteData (new value) combinationally.
  - This lets writeback and decode share a cycle without a hazard.
- Bypass applies to both ports simultaneously when both match.
- Simultaneous reset and write: reset wins; the register stays 0.
- Reset asserted mid-operation: state clears at once and outputs go 0. After deassertion, the first write takes effect at the next rising edge with RegWrite=1.
- Addresses are exactly ADDR_W bits wide; no out-of-range handling is required.
- No X is ever driven on any output after reset.

Test Plan:
- Reset: hold rstn=0 for 20 ns with RegRead_1=RegRead_2=1 and random addresses -> ReadData_1=ReadData_2=0 and x0..x31 all 0x00000000.
- Write/read sweep: after reset, write reg[i]=0xA5A50000+i for i=1..31, one per clock -> x<i> = 0xA5A50000+i after each edge. Then sweep ReadAddr_1 upward 0..31 while ReadAddr_2 sweeps downward 31..0 -> each port returns the stored value, and 0 for address 0.
- x0 protection: RegWrite=1, WriteAddr=0, WriteData=0xFFFFFFFF, then clock -> x0=0, and ReadData_1 with ReadAddr_1=0 is 0.
- Read enable gating: with reg[5]=0x12345678, ReadAddr_1=ReadAddr_2=5, toggle RegRead_1/RegRead_2 every 10 ns -> ReadData outputs alternate between 0x12345678 and 0 in lockstep with the enables.
- Bypass: reg[7]=0x11111111, RegWrite=1, WriteAddr=7, WriteData=0x22222222, ReadAddr_1=7, RegRead_1=1 -> ReadData_1=0x22222222 before the edge. After the edge, x7=0x22222222.
- Async reset mid-run: with registers loaded, pull rstn low between clock edges -> all outputs become 0 without waiting for a clock edge. After release, prior contents remain 0.
